// File: rtl/bip_datapath.sv
// BIP accumulator datapath: sign-extended immediates, internal data memory,
// add/subtract ALU, registered accumulator and sticky signed-overflow flag.
module bip_datapath #(
  parameter int len_data  = 16,
  parameter int len_addr  = 11,
  parameter int len_mux_a = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [len_addr-1:0]  Operand,
  input  logic [len_mux_a-1:0] SelA,
  input  logic                 SelB,
  input  logic                 WrAcc,
  input  logic                 Op,
  input  logic                 WrRam,
  input  logic                 RdRam,
  output logic [len_data-1:0]  Acc,
  output logic                 Ovf
);

  typedef enum logic [len_mux_a-1:0] {
    SEL_RD  = len_mux_a'(0),
    SEL_EXT = len_mux_a'(1),
    SEL_RES = len_mux_a'(2),
    SEL_ACC = len_mux_a'(3)
  } accSel_t;

  logic [len_data-1:0] dataMem [2**len_addr];

  logic [len_data-1:0] ext;
  logic [len_data-1:0] rd;
  logic [len_data-1:0] opB;
  logic [len_data-1:0] res;
  logic [len_data-1:0] accIn;
  logic                ovfEvent;
  accSel_t             selA;

  assign selA = accSel_t'(SelA);

  // Operand decoding, memory read and ALU operand selection
  always_comb begin
    ext = {{(len_data-len_addr){Operand[len_addr-1]}}, Operand};
    rd  = RdRam ? dataMem[Operand] : '0;
    opB = SelB ? ext : rd;
  end

  // ALU and signed-overflow detection (sub overflows when operand signs differ)
  always_comb begin
    res      = Op ? (Acc - opB) : (Acc + opB);
    ovfEvent = 1'b0;
    if (Op)
      ovfEvent = (Acc[len_data-1] != opB[len_data-1]) &&
                 (res[len_data-1] != Acc[len_data-1]);
    else
      ovfEvent = (Acc[len_data-1] == opB[len_data-1]) &&
                 (res[len_data-1] != Acc[len_data-1]);
  end

  // Accumulator input multiplexer
  always_comb begin
    accIn = Acc;
    case (selA)
      SEL_RD:  accIn = rd;
      SEL_EXT: accIn = ext;
      SEL_RES: accIn = res;
      SEL_ACC: accIn = Acc;
      default: accIn = Acc;
    endcase
  end

  // Data memory write of the pre-edge accumulator; blocked during reset, never cleared
  always_ff @(posedge clk) begin
    if (!reset && WrRam)
      dataMem[Operand] <= Acc;
  end

  // Accumulator and sticky overflow registers
  always_ff @(posedge clk) begin
    if (reset) begin
      Acc <= '0;
      Ovf <= 1'b0;
    end else if (WrAcc) begin
      Acc <= accIn;
      if (selA == SEL_RES && ovfEvent)
        Ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bip_datapath.sv
// Self-checking bench for bip_datapath: directed scenarios followed by
// randomized instruction streams checked against an integer reference model.
module tb_bip_datapath;

  logic        clk;
  logic        reset;
  logic [10:0] Operand;
  logic [1:0]  SelA;
  logic        SelB;
  logic        WrAcc;
  logic        Op;
  logic        WrRam;
  logic        RdRam;
  logic [15:0] Acc;
  logic        Ovf;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0] mAcc;
  logic        mOvf;
  logic [15:0] mMem [2048];

  bip_datapath #(.len_data(16), .len_addr(11), .len_mux_a(2)) dut (
    .clk(clk), .reset(reset), .Operand(Operand), .SelA(SelA), .SelB(SelB),
    .WrAcc(WrAcc), .Op(Op), .WrRam(WrRam), .RdRam(RdRam), .Acc(Acc), .Ovf(Ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int toSigned16(input logic [15:0] v);
    int s;
    s = int'(v);
    if (s >= 32768) s = s - 65536;
    return s;
  endfunction

  task automatic check16(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  // One instruction: drive, clock, advance the model, compare Acc and Ovf
  task automatic step(input bit rst, input int operand, input int selA, input bit selB,
                      input bit wrAcc, input bit op, input bit wrRam, input bit rdRam,
                      input string tag);
    int extS, bS, exact;
    logic [15:0] rdV, extV, bV, resV, nextAcc;
    bit ovfEv;
    extS    = (operand >= 1024) ? operand - 2048 : operand;
    extV    = 16'(extS);
    rdV     = rdRam ? mMem[operand] : 16'h0000;
    bV      = selB ? extV : rdV;
    bS      = toSigned16(bV);
    exact   = op ? toSigned16(mAcc) - bS : toSigned16(mAcc) + bS;
    resV    = 16'(exact);
    ovfEv   = (exact > 32767) || (exact < -32768);
    nextAcc = (selA == 0) ? rdV : (selA == 1) ? extV : (selA == 2) ? resV : mAcc;

    reset   = rst;
    Operand = 11'(operand);
    SelA    = 2'(selA);
    SelB    = selB;
    WrAcc   = wrAcc;
    Op      = op;
    WrRam   = wrRam;
    RdRam   = rdRam;
    @(posedge clk);
    #1;

    if (rst) begin
      mAcc = 16'h0000;
      mOvf = 1'b0;
    end else begin
      if (wrRam) mMem[operand] = mAcc;
      if (wrAcc) begin
        if (selA == 2 && ovfEv) mOvf = 1'b1;
        mAcc = nextAcc;
      end
    end
    check16({tag, ".Acc"}, Acc, mAcc);
    check1({tag, ".Ovf"}, Ovf, mOvf);
  endtask

  task automatic halt(input string tag);
    step(0, 0, 0, 0, 0, 0, 0, 0, tag);
  endtask

  initial begin
    mAcc = 16'h0000;
    mOvf = 1'b0;
    reset = 1'b1; Operand = '0; SelA = '0; SelB = 1'b0;
    WrAcc = 1'b0; Op = 1'b0; WrRam = 1'b0; RdRam = 1'b0;

    // Reset overrides a pending load
    step(1, 'h155, 1, 0, 1, 0, 0, 0, "reset");
    check16("resetAcc", Acc, 16'h0000);

    // Load immediate with sign extension
    step(0, 'h7FB, 1, 0, 1, 0, 0, 0, "ldiNeg");
    check16("ldiNegConst", Acc, 16'hFFFB);
    step(0, 'h3FF, 1, 0, 1, 0, 0, 0, "ldiPosMax");

    // Store / load
    step(0, 'h155, 1, 0, 1, 0, 0, 0, "ldi155");
    step(0, 5, 0, 0, 0, 0, 1, 0, "sto5");
    step(0, 0, 1, 0, 1, 0, 0, 0, "ldi0");
    step(0, 5, 0, 0, 1, 0, 0, 1, "ld5");
    check16("ld5Const", Acc, 16'h0155);

    // Store and load in the same cycle: memory gets old Acc, read sees old data
    step(0, 'h0AA, 1, 0, 1, 0, 0, 0, "ldiAA");
    step(0, 5, 0, 0, 1, 0, 1, 1, "ldSto5");
    check16("ldSto5Const", Acc, 16'h0155);
    step(0, 5, 0, 0, 1, 0, 0, 1, "ld5After");
    check16("ld5AfterConst", Acc, 16'h00AA);

    // Subtract variable
    step(0, 10, 1, 0, 1, 0, 0, 0, "ldi10");
    step(0, 3, 0, 0, 0, 0, 1, 0, "sto3");
    step(0, 4, 1, 0, 1, 0, 0, 0, "ldi4");
    step(0, 3, 2, 0, 1, 1, 0, 1, "sub3");
    check16("sub3Const", Acc, 16'hFFFA);
    check1("sub3Ovf", Ovf, 1'b0);

    // RdRam low gives zero read data
    step(0, 3, 0, 0, 1, 0, 0, 0, "ldNoRd");

    // Sticky overflow
    step(0, 'h3FF, 1, 0, 1, 0, 0, 0, "ldi3FF");
    step(0, 'h3FF, 3, 0, 1, 0, 0, 0, "hold");
    step(0, 0, 1, 0, 1, 0, 0, 0, "ldi0b");
    step(0, 'h3FF, 1, 0, 1, 0, 0, 0, "ldi3FFb");
    step(0, 'h3FF, 0, 0, 0, 0, 1, 0, "sto3FF");
    // Build 0x7FFF as 0x3FF * 32 + 31 via repeated adds of memory word
    for (int i = 0; i < 31; i++) step(0, 'h3FF, 2, 0, 1, 0, 0, 1, "build");
    step(0, 31, 2, 1, 1, 0, 0, 0, "build31");
    check16("build7FFF", Acc, 16'h7FFF);
    step(0, 1, 2, 1, 1, 0, 0, 0, "addOvf");
    check16("addOvfAcc", Acc, 16'h8000);
    check1("addOvfFlag", Ovf, 1'b1);
    halt("halt1");
    halt("halt2");
    check1("ovfSticky", Ovf, 1'b1);
    step(0, 0, 1, 0, 1, 0, 0, 0, "ldAfterOvf");
    check1("ovfStickyLd", Ovf, 1'b1);

    // Write suppression under reset
    step(0, 'h011, 1, 0, 1, 0, 0, 0, "ldi11");
    step(0, 7, 0, 0, 0, 0, 1, 0, "sto7");
    step(0, 'h042, 1, 0, 1, 0, 0, 0, "ldi42");
    step(1, 7, 0, 0, 0, 0, 1, 0, "rstSto7");
    check1("rstOvfClr", Ovf, 1'b0);
    step(0, 7, 0, 0, 1, 0, 0, 1, "ld7");
    check16("ld7Const", Acc, 16'h0011);

    // Initialise a small memory window for random reads
    for (int a = 0; a < 16; a++) begin
      step(0, int'($urandom_range(0, 2047)), 1, 0, 1, 0, 0, 0, "initLd");
      step(0, a, 0, 0, 0, 0, 1, 0, "initSto");
    end

    // Randomized instruction stream
    for (int unsigned n = 0; n < 400; n++) begin
      bit rd;
      int opd;
      rd  = ($urandom_range(0, 1) == 1);
      opd = rd ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 2047));
      if (($urandom_range(0, 1) == 1) && !rd && $urandom_range(0, 1) == 1)
        opd = int'($urandom_range(0, 15));
      step(($urandom_range(0, 63) == 0), opd, int'($urandom_range(0, 3)),
           $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
           $urandom_range(0, 1) == 1,
           ($urandom_range(0, 3) == 0) && (opd < 16), rd, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
